// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 16-point CORDIC FFT core and its loader.
package fft_pkg;

  localparam int unsigned FFT_N  = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned OUT_W  = 17;
  localparam int unsigned IDX_W  = $clog2(FFT_N);

  typedef logic [IDX_W-1:0] idx_t;

  // Returns slice k of a flat FFT_N x DATA_W bus (slice k feeds xin/yin k+1).
  function automatic logic [DATA_W-1:0] bus_slice(input logic [FFT_N*DATA_W-1:0] bus,
                                                  input int unsigned k);
    return bus[k*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/fft_hold_timer.sv
// Saturating hold counter: guarantees a presented frame stays put for HOLD_CYCLES cycles.
module fft_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic hold_ok_o
);

  localparam logic [7:0] HoldMax = 8'(HOLD_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (cnt_q < HoldMax) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Resetting to the saturated value lets the first frame present immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= HoldMax;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hold_ok_o = (cnt_q >= HoldMax);

endmodule

// File: rtl/fft_in_frame_loader.sv
// Assembles a serial complex sample stream into 16-sample frames and presents them,
// double-buffered, as stable parallel buses for the FFT core inputs.
module fft_in_frame_loader #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned FFT_N       = 16,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_x,
  input  logic [DATA_W-1:0]       s_y,
  input  logic                    s_last,
  input  logic                    err_clear,
  output logic [FFT_N*DATA_W-1:0] frame_x,
  output logic [FFT_N*DATA_W-1:0] frame_y,
  output logic                    frame_strobe,
  output logic                    frame_valid,
  output logic [15:0]             frame_count,
  output logic                    err_framing
);

  import fft_pkg::idx_t;

  if (FFT_N != 16) begin : g_bad_fft_n
    $error("fft_in_frame_loader supports FFT_N == 16 only");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("fft_in_frame_loader HOLD_CYCLES must be in 1..255");
  end

  localparam idx_t LastIdx = idx_t'(FFT_N - 1);

  idx_t                    wr_idx_q, wr_idx_d;
  logic [FFT_N*DATA_W-1:0] fill_x_q, fill_x_d, fill_y_q, fill_y_d;
  logic [FFT_N*DATA_W-1:0] frame_x_q, frame_x_d, frame_y_q, frame_y_d;
  logic                    full_q, full_d;
  logic                    strobe_q, valid_q, valid_d, err_q, err_d;
  logic [15:0]             count_q, count_d;

  logic hold_ok, accept, at_last, complete, early_last, late_last, transfer;

  assign s_ready    = !full_q;
  assign accept     = s_valid && s_ready;
  assign at_last    = (wr_idx_q == LastIdx);
  assign early_last = accept && s_last && !at_last;
  assign late_last  = accept && !s_last && at_last;
  assign complete   = accept && at_last;
  // full_q and complete are mutually exclusive since accept needs s_ready.
  assign transfer   = hold_ok && (full_q || complete);

  fft_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .restart_i(transfer),
    .hold_ok_o(hold_ok)
  );

  always_comb begin
    wr_idx_d = wr_idx_q;
    fill_x_d = fill_x_q;
    fill_y_d = fill_y_q;
    if (accept) begin
      if (early_last) begin
        wr_idx_d = '0;
      end else begin
        fill_x_d[int'(wr_idx_q)*DATA_W +: DATA_W] = s_x;
        fill_y_d[int'(wr_idx_q)*DATA_W +: DATA_W] = s_y;
        wr_idx_d = wr_idx_q + idx_t'(1);
      end
    end

    full_d = full_q;
    if (transfer) begin
      full_d = 1'b0;
    end else if (complete) begin
      full_d = 1'b1;
    end

    // Sourcing from fill_*_d lets the completing sample bypass straight into slot 15.
    frame_x_d = frame_x_q;
    frame_y_d = frame_y_q;
    if (transfer) begin
      frame_x_d = fill_x_d;
      frame_y_d = fill_y_d;
    end

    valid_d = valid_q || transfer;
    count_d = count_q + {15'd0, transfer};

    err_d = err_q;
    if (err_clear) begin
      err_d = 1'b0;
    end
    if (early_last || late_last) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_idx_q  <= '0;
      fill_x_q  <= '0;
      fill_y_q  <= '0;
      frame_x_q <= '0;
      frame_y_q <= '0;
      full_q    <= 1'b0;
      strobe_q  <= 1'b0;
      valid_q   <= 1'b0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      fill_x_q  <= fill_x_d;
      fill_y_q  <= fill_y_d;
      frame_x_q <= frame_x_d;
      frame_y_q <= frame_y_d;
      full_q    <= full_d;
      strobe_q  <= transfer;
      valid_q   <= valid_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  assign frame_x      = frame_x_q;
  assign frame_y      = frame_y_q;
  assign frame_strobe = strobe_q;
  assign frame_valid  = valid_q;
  assign frame_count  = count_q;
  assign err_framing  = err_q;

endmodule

// File: tb/tb_fft_in_frame_loader.sv
// Scoreboard bench for fft_in_frame_loader: default hold (a_*) and HOLD_CYCLES=20 (b_*).
module tb_fft_in_frame_loader;
  import fft_pkg::*;

  localparam int unsigned BW = FFT_N * DATA_W;

  typedef struct {
    logic [BW-1:0] x;
    logic [BW-1:0] y;
    logic [15:0]   cnt;
  } exp_t;

  exp_t sb[$];
  int   b_times[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;

  logic clock = 1'b0;
  logic rst_n = 1'b1;

  logic a_valid = 1'b0, a_last = 1'b0, a_clr = 1'b0;
  logic [DATA_W-1:0] a_x = '0, a_y = '0;
  logic a_ready, a_strobe, a_fvalid, a_err;
  logic [BW-1:0] a_fx, a_fy;
  logic [15:0] a_count;

  logic b_valid = 1'b0, b_last = 1'b0;
  logic [DATA_W-1:0] b_x = '0, b_y = '0;
  logic b_ready, b_strobe, b_fvalid, b_err;
  logic [BW-1:0] b_fx, b_fy;
  logic [15:0] b_count;

  logic [DATA_W-1:0] ex[FFT_N];
  logic [DATA_W-1:0] ey[FFT_N];
  logic [15:0] cnt_a = 0, cnt_b = 0;

  fft_in_frame_loader #(
    .DATA_W(DATA_W), .FFT_N(FFT_N), .HOLD_CYCLES(16)
  ) dut (
    .clock(clock), .reset_n(rst_n), .s_valid(a_valid), .s_ready(a_ready), .s_x(a_x), .s_y(a_y),
    .s_last(a_last), .err_clear(a_clr), .frame_x(a_fx), .frame_y(a_fy),
    .frame_strobe(a_strobe), .frame_valid(a_fvalid), .frame_count(a_count),
    .err_framing(a_err)
  );

  fft_in_frame_loader #(
    .DATA_W(DATA_W), .FFT_N(FFT_N), .HOLD_CYCLES(20)
  ) dut20 (
    .clock(clock), .reset_n(rst_n), .s_valid(b_valid), .s_ready(b_ready), .s_x(b_x), .s_y(b_y),
    .s_last(b_last), .err_clear(1'b0), .frame_x(b_fx), .frame_y(b_fy),
    .frame_strobe(b_strobe), .frame_valid(b_fvalid), .frame_count(b_count),
    .err_framing(b_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [BW-1:0] x, input logic [BW-1:0] y,
                           input logic [15:0] c, input logic v);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_unexpected_strobe: got strobe with count %0d, required none", tag, c);
    end else begin
      e = sb.pop_front();
      check({tag, "_frame_x"}, x, e.x);
      check({tag, "_frame_y"}, y, e.y);
      check({tag, "_frame_count"}, BW'(c), BW'(e.cnt));
      check({tag, "_frame_valid"}, BW'(v), BW'(1));
    end
  endtask

  always @(negedge clock) begin
    if (rst_n && a_strobe) chk_frame("a", a_fx, a_fy, a_count, a_fvalid);
    if (rst_n && b_strobe) begin
      b_times.push_back(cyc);
      chk_frame("b", b_fx, b_fy, b_count, b_fvalid);
    end
  end

  task automatic expect_frame(input bit w);
    exp_t e;
    for (int k = 0; k < int'(FFT_N); k++) begin
      e.x[k*DATA_W +: DATA_W] = ex[k];
      e.y[k*DATA_W +: DATA_W] = ey[k];
    end
    if (w) begin
      cnt_b++;
      e.cnt = cnt_b;
    end else begin
      cnt_a++;
      e.cnt = cnt_a;
    end
    sb.push_back(e);
  endtask

  // Presents one sample and retries until it is accepted (bounded).
  task automatic push(input bit w, input logic [15:0] x, input logic [15:0] y,
                      input logic last, input logic clr);
    bit acc = 1'b0;
    int tries = 0;
    while (!acc && tries < 100) begin
      if (w) begin
        b_valid = 1'b1; b_x = x; b_y = y; b_last = last; acc = b_ready;
      end else begin
        a_valid = 1'b1; a_x = x; a_y = y; a_last = last; a_clr = clr; acc = a_ready;
      end
      @(posedge clock);
      #1;
      tries++;
    end
    a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0; a_clr = 1'b0;
    if (!acc) begin
      n_checks++;
      n_err++;
      $display("FAIL push_timeout: got no accept in %0d cycles, required accept", tries);
    end
  endtask

  task automatic idle(input logic clr, input logic [15:0] gx);
    a_valid = 1'b0; a_x = gx; a_y = gx; a_clr = clr;
    @(posedge clock);
    #1;
    a_clr = 1'b0;
  endtask

  initial begin
    logic rdy_ok;
    int n;

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    check("rst_ready", BW'(a_ready), BW'(1));
    check("rst_fvalid", BW'(a_fvalid), BW'(0));
    check("rst_count", BW'(a_count), BW'(0));
    check("rst_err", BW'(a_err), BW'(0));
    check("rst_strobe", BW'(a_strobe), BW'(0));
    check("rst_frame_x", a_fx, '0);
    @(negedge clock) rst_n = 1'b1;
    @(posedge clock);
    #1;

    // Two back-to-back frames: x=k,y=-k then x=0x100+k,y=3k
    rdy_ok = 1'b1;
    for (int k = 0; k < 16; k++) begin
      ex[k] = 16'(k);
      ey[k] = -16'(k);
    end
    for (int k = 0; k < 16; k++) begin
      if (k == 15) expect_frame(0);
      push(0, 16'(k), -16'(k), logic'(k == 15), 1'b0);
      rdy_ok &= a_ready;
    end
    check("f1_strobe", BW'(a_strobe), BW'(1));
    check("f1_slot15_x", BW'(bus_slice(a_fx, 15)), BW'(16'd15));
    check("f1_slot15_y", BW'(bus_slice(a_fy, 15)), BW'(16'hfff1));
    for (int k = 0; k < 16; k++) begin
      ex[k] = 16'h0100 + 16'(k);
      ey[k] = 16'(3 * k);
    end
    for (int k = 0; k < 16; k++) begin
      if (k == 15) expect_frame(0);
      push(0, 16'h0100 + 16'(k), 16'(3 * k), logic'(k == 15), 1'b0);
      rdy_ok &= a_ready;
    end
    check("f2_strobe", BW'(a_strobe), BW'(1));
    check("b2b_ready_high", BW'(rdy_ok), BW'(1));

    // Early s_last on the 6th sample discards the partial frame
    for (int k = 0; k < 6; k++) push(0, 16'h0111, 16'h0222, logic'(k == 5), 1'b0);
    check("early_last_err", BW'(a_err), BW'(1));
    check("early_last_nostrobe", BW'(a_strobe), BW'(0));
    for (int k = 0; k < 16; k++) begin
      ex[k] = 16'h0200 + 16'(k);
      ey[k] = 16'h0300 + 16'(k);
    end
    for (int k = 0; k < 16; k++) begin
      if (k == 15) expect_frame(0);
      push(0, 16'h0200 + 16'(k), 16'h0300 + 16'(k), logic'(k == 15), 1'b0);
    end
    check("after_err_strobe", BW'(a_strobe), BW'(1));

    // err_clear with a simultaneous new error: set wins; then clear alone
    push(0, 16'h0abc, 16'h0abc, 1'b1, 1'b1);
    check("clr_and_set_err", BW'(a_err), BW'(1));
    idle(1'b1, 16'h0000);
    check("clr_alone_err", BW'(a_err), BW'(0));

    // Missing s_last on the 16th sample: error, but the frame still transfers
    for (int k = 0; k < 16; k++) begin
      ex[k] = 16'h7000 + 16'(k);
      ey[k] = 16'h8000 - 16'(k);
    end
    for (int k = 0; k < 16; k++) begin
      if (k == 15) expect_frame(0);
      push(0, 16'h7000 + 16'(k), 16'h8000 - 16'(k), 1'b0, 1'b0);
    end
    check("late_last_err", BW'(a_err), BW'(1));
    check("late_last_strobe", BW'(a_strobe), BW'(1));
    idle(1'b1, 16'h0000);

    // Random s_valid gaps; garbage on idle cycles must never appear
    for (int k = 0; k < 16; k++) begin
      ex[k] = 16'h0400 + 16'(k);
      ey[k] = 16'h0800 + 16'(k);
    end
    expect_frame(0);
    n = 0;
    for (int t = 0; t < 300 && n < 16; t++) begin
      if ($urandom_range(1, 0) == 1) begin
        push(0, 16'h0400 + 16'(n), 16'h0800 + 16'(n), logic'(n == 15), 1'b0);
        n++;
      end else begin
        idle(1'b0, 16'hdead);
      end
    end
    check("gap_strobe", BW'(a_strobe), BW'(1));

    // Asynchronous reset mid-frame after 9 samples (with err set beforehand)
    repeat (16) idle(1'b0, 16'h0000);
    push(0, 16'h0001, 16'h0001, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) push(0, 16'h0900 + 16'(k), 16'h0900, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_fvalid", BW'(a_fvalid), BW'(0));
    check("mid_rst_count", BW'(a_count), BW'(0));
    check("mid_rst_err", BW'(a_err), BW'(0));
    check("mid_rst_frame_x", a_fx, '0);
    check("mid_rst_frame_y", a_fy, '0);
    cnt_a = 0;
    @(negedge clock) rst_n = 1'b1;
    @(posedge clock);
    #1;
    for (int k = 0; k < 16; k++) begin
      ex[k] = 16'h0c00 + 16'(k);
      ey[k] = 16'h0d00 + 16'(k);
    end
    for (int k = 0; k < 16; k++) begin
      if (k == 15) expect_frame(0);
      push(0, 16'h0c00 + 16'(k), 16'h0d00 + 16'(k), logic'(k == 15), 1'b0);
    end
    check("post_rst_count", BW'(a_count), BW'(1));

    // HOLD_CYCLES=20: second frame stalls until the hold window expires
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 16; k++) begin
        ex[k] = 16'h0500 + 16'(16 * f + k);
        ey[k] = 16'h0600 + 16'(16 * f + k);
      end
      for (int k = 0; k < 16; k++) begin
        if (k == 15) expect_frame(1);
        push(1, 16'h0500 + 16'(16 * f + k), 16'h0600 + 16'(16 * f + k), logic'(k == 15), 1'b0);
      end
    end
    check("hold20_ready_drop", BW'(b_ready), BW'(0));
    for (int t = 0; t < 40 && b_times.size() < 2; t++) @(posedge clock);
    #1;
    check("hold20_strobes", BW'(b_times.size()), BW'(2));
    if (b_times.size() == 2) check("hold20_spacing", BW'(b_times[1] - b_times[0]), BW'(20));
    check("hold20_count", BW'(b_count), BW'(2));
    check("hold20_ready_back", BW'(b_ready), BW'(1));

    repeat (3) @(posedge clock);
    check("sb_drained", BW'(sb.size()), BW'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
